fb_access_ctrl: RTL and testbench

Single-port framebuffer access controller between the rasterizer pixel stream, a clear engine and the display scan-out reader. It linearises pixel (x, y) to a memory address. It arbitrates one memory access per cycle and sequences full-screen clears. It sits after rasterization and replaces direct array writes with a shared single-port RAM interface.

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_addr_gen.sv | 16 +
 rtl/fb_access_ctrl.sv | 128 ++++++++++++
 tb/tb_fb_access_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer access path.
package fb_pkg;
  localparam int COLOR_W       = 24;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int FB_DEPTH      = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int PIX_XW        = 10;
  localparam int PIX_YW        = 9;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} fb_state_t;
endpackage

// File: rtl/fb_addr_gen.sv
// Pixel (x, y) range check and row-major linearisation; purely combinational.
module fb_addr_gen #(
  parameter int WIDTH  = fb_pkg::SCREEN_WIDTH,
  parameter int HEIGHT = fb_pkg::SCREEN_HEIGHT,
  parameter int ADDR_W = 19,
  parameter int XW     = fb_pkg::PIX_XW,
  parameter int YW     = fb_pkg::PIX_YW
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  output logic              in_range,
  output logic [ADDR_W-1:0] addr
);
  assign in_range = (32'(x) < 32'(WIDTH)) && (32'(y) < 32'(HEIGHT));
  assign addr     = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
endmodule

// File: rtl/fb_access_ctrl.sv
// Single-port framebuffer arbiter: scan-out reads, raster writes and clear sweeps,
// one memory access per cycle with bounded write starvation.
module fb_access_ctrl
  import fb_pkg::*;
#(
  parameter int SCREEN_WIDTH  = fb_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = fb_pkg::SCREEN_HEIGHT,
  parameter int ADDR_W        = 19,
  parameter int COLOR_W       = fb_pkg::COLOR_W,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [9:0]         pix_x,
  input  logic [8:0]         pix_y,
  input  logic [COLOR_W-1:0] pix_rgb,
  input  logic               scan_req,
  input  logic [ADDR_W-1:0]  scan_addr,
  output logic               scan_gnt,
  output logic               scan_rvalid,
  output logic [COLOR_W-1:0] scan_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [15:0]        drop_count
);
  localparam int DEPTH = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  fb_state_t          state, state_nxt;
  logic [SW-1:0]      starve_cnt;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [COLOR_W-1:0] clr_color;
  logic               vld_q;
  logic               pix_in_range;
  logic [ADDR_W-1:0]  pix_addr;
  logic               wr_pend, scan_win, gnt_scan, gnt_wr, gnt_pix, gnt_clr, clr_last;

  fb_addr_gen #(
    .WIDTH (SCREEN_WIDTH),
    .HEIGHT(SCREEN_HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_addr (
    .x       (pix_x),
    .y       (pix_y),
    .in_range(pix_in_range),
    .addr    (pix_addr)
  );

  // Grants are gated by reset so every memory-side output is quiet while held.
  assign wr_pend  = (state == CLEAR) || pix_valid;
  assign scan_win = scan_req && (starve_cnt < SW'(STARVE_LIMIT));
  assign gnt_scan = reset_n && scan_win;
  assign gnt_wr   = reset_n && wr_pend && !scan_win;
  assign gnt_pix  = gnt_wr && (state == RUN);
  assign gnt_clr  = gnt_wr && (state == CLEAR);
  assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:   if (clear_req) state_nxt = CLEAR;
      CLEAR: if (gnt_clr && clr_last) state_nxt = RUN;
    endcase
  end

  always_comb begin
    clear_busy = (state == CLEAR);
    pix_ready  = gnt_pix;
    scan_gnt   = gnt_scan;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (gnt_scan) begin
      mem_en   = 1'b1;
      mem_addr = scan_addr;
    end else if (gnt_clr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = clr_color;
    end else if (gnt_pix && pix_in_range) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = pix_addr;
      mem_wdata = pix_rgb;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      clr_cnt    <= '0;
      clr_color  <= '0;
      drop_count <= '0;
      vld_q      <= 1'b0;
    end else begin
      vld_q <= gnt_scan;
      // Only a scan win over a waiting write counts toward starvation.
      if (wr_pend && gnt_scan) starve_cnt <= starve_cnt + SW'(1);
      else                     starve_cnt <= '0;
      if (state == RUN && clear_req) begin
        clr_cnt   <= '0;
        clr_color <= clear_color;
      end else if (gnt_clr) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
      end
      if (gnt_pix && !pix_in_range && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  assign scan_rvalid = vld_q;
  assign scan_rdata  = mem_rdata;
endmodule

// File: tb/tb_fb_access_ctrl.sv
// Directed bench for fb_access_ctrl with a scoreboard of expected memory accesses.
module tb_fb_access_ctrl;
  import fb_pkg::*;

  localparam int W     = 640;
  localparam int H     = 48;
  localparam int DEPTH = W * H;
  localparam int AW    = 19;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } acc_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear_req = 1'b0;
  logic [23:0]   clear_color = '0;
  logic          clear_busy;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [9:0]    pix_x = '0;
  logic [8:0]    pix_y = '0;
  logic [23:0]   pix_rgb = '0;
  logic          scan_req = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic          scan_gnt, scan_rvalid;
  logic [23:0]   scan_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata;
  logic [23:0]   mem_rdata = '0;
  logic [15:0]   drop_count;

  int   checks = 0;
  int   errors = 0;
  acc_t exp_q[$];

  fb_access_ctrl #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .ADDR_W       (AW),
    .COLOR_W      (24),
    .STARVE_LIMIT (8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
    .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rd_pat(logic [AW-1:0] a);
    return {5'h0, a} ^ 24'hA5C3E1;
  endfunction

  // Synchronous-read memory stand-in: data is a pattern of the address read.
  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= rd_pat(mem_addr);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic we, logic [AW-1:0] a, logic [23:0] d);
    acc_t e;
    e.we = we; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(logic v, int x, int y, logic [23:0] rgb);
    pix_valid = v; pix_x = 10'(x); pix_y = 9'(y); pix_rgb = rgb;
  endtask

  always @(negedge clk) begin
    if (reset_n && mem_en) begin
      if (exp_q.size() == 0) chk("unexpected_access", 32'(mem_addr), 32'hFFFF_FFFF);
      else begin
        acc_t e;
        e = exp_q.pop_front();
        chk("acc_we", 32'(mem_we), 32'(e.we));
        chk("acc_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) chk("acc_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    int  busy;
    logic es, prev_es;
    logic [AW-1:0] sa, prev_sa;
    int  px;

    // Reset held with requests present: everything quiet.
    set_pix(1'b1, 10, 2, 24'hFF0000);
    scan_req = 1'b1; scan_addr = 19'd5;
    @(negedge clk); @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_scan_gnt", 32'(scan_gnt), 32'd0);
    chk("rst_scan_rvalid", 32'(scan_rvalid), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    tick();
    reset_n = 1'b1; scan_req = 1'b0;
    push(1'b1, 19'd1290, 24'hFF0000);
    @(negedge clk);
    chk("px_ready", 32'(pix_ready), 32'd1);
    chk("px_we", 32'(mem_we), 32'd1);
    chk("px_addr", 32'(mem_addr), 32'd1290);
    chk("px_wdata", 32'(mem_wdata), 32'hFF0000);

    // Out-of-range pixels on each axis boundary, then the last in-range pixel.
    tick(); set_pix(1'b1, W, 0, 24'h111111);
    @(negedge clk);
    chk("oor_x_ready", 32'(pix_ready), 32'd1);
    chk("oor_x_en", 32'(mem_en), 32'd0);
    tick(); set_pix(1'b1, 0, H, 24'h222222);
    @(negedge clk);
    chk("oor_y_ready", 32'(pix_ready), 32'd1);
    chk("oor_y_en", 32'(mem_en), 32'd0);
    tick(); set_pix(1'b1, W - 1, H - 1, 24'h333333);
    push(1'b1, 19'(DEPTH - 1), 24'h333333);
    @(negedge clk);
    chk("corner_addr", 32'(mem_addr), 32'(DEPTH - 1));
    tick(); pix_valid = 1'b0;
    @(negedge clk);
    chk("drop_count", 32'(drop_count), 32'd2);

    // Scan beats a pending pixel; read data one cycle later.
    tick(); set_pix(1'b1, 1, 0, 24'h0A0B0C);
    scan_req = 1'b1; scan_addr = 19'd5;
    push(1'b0, 19'd5, 24'h0);
    push(1'b1, 19'd1, 24'h0A0B0C);
    @(negedge clk);
    chk("prio_scan_gnt", 32'(scan_gnt), 32'd1);
    chk("prio_pix_ready", 32'(pix_ready), 32'd0);
    tick(); scan_req = 1'b0;
    @(negedge clk);
    chk("lat_rvalid", 32'(scan_rvalid), 32'd1);
    chk("lat_rdata", 32'(scan_rdata), 32'(rd_pat(19'd5)));
    chk("lat_pix_ready", 32'(pix_ready), 32'd1);
    tick(); pix_valid = 1'b0;
    @(negedge clk);
    chk("lat_rvalid_low", 32'(scan_rvalid), 32'd0);

    // Starvation: 8 scan wins, then one forced write, repeating.
    sa = 19'd200; px = 20; prev_es = 1'b0; prev_sa = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      es = (i % 9) != 8;
      scan_req = 1'b1; scan_addr = sa;
      set_pix(1'b1, px, 3, 24'h0000FF ^ 24'(px));
      if (es) push(1'b0, sa, 24'h0);
      else    push(1'b1, 19'(3 * W + px), 24'h0000FF ^ 24'(px));
      @(negedge clk);
      chk($sformatf("starve_gnt_%0d", i), 32'(scan_gnt), 32'(es));
      chk($sformatf("starve_ready_%0d", i), 32'(pix_ready), 32'(!es));
      if (i > 0) begin
        chk($sformatf("starve_rvalid_%0d", i), 32'(scan_rvalid), 32'(prev_es));
        if (prev_es) chk($sformatf("starve_rdata_%0d", i), 32'(scan_rdata), 32'(rd_pat(prev_sa)));
      end
      prev_es = es; prev_sa = sa;
      if (es) sa = sa + 19'd1;
      else    px++;
    end
    tick(); scan_req = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    chk("starve_last_rdata", 32'(scan_rdata), 32'(rd_pat(prev_sa)));

    // Clear requested together with a pixel handshake; a second request mid-sweep is ignored.
    tick();
    clear_req = 1'b1; clear_color = 24'h000080;
    set_pix(1'b1, 3, 1, 24'h123123);
    push(1'b1, 19'd643, 24'h123123);
    for (int a = 0; a < DEPTH; a++) push(1'b1, 19'(a), 24'h000080);
    push(1'b1, 19'd644, 24'h00FF00);
    @(negedge clk);
    chk("clr_start_ready", 32'(pix_ready), 32'd1);
    chk("clr_start_busy", 32'(clear_busy), 32'd0);
    tick();
    clear_req = 1'b0; clear_color = 24'hFFFFFF;
    set_pix(1'b1, 4, 1, 24'h00FF00);
    busy = 0;
    for (int c = 0; c < DEPTH + 10; c++) begin
      @(negedge clk);
      if (!clear_busy) break;
      busy++;
      chk("clr_pix_ready", 32'(pix_ready), 32'd0);
      tick();
      clear_req = (c == 500);
    end
    chk("clr_busy_cycles", 32'(busy), 32'(DEPTH));
    chk("clr_run_ready", 32'(pix_ready), 32'd1);
    tick(); pix_valid = 1'b0; clear_req = 1'b0;

    // Reset at clear count 1000 aborts the sweep.
    clear_req = 1'b1; clear_color = 24'h445566;
    for (int a = 0; a < 1000; a++) push(1'b1, 19'(a), 24'h445566);
    tick(); clear_req = 1'b0;
    repeat (1000) tick();
    reset_n = 1'b0; set_pix(1'b1, 0, 0, 24'hABCDEF);
    #1;
    chk("abort_busy", 32'(clear_busy), 32'd0);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_pix_ready", 32'(pix_ready), 32'd0);
    tick(); reset_n = 1'b1;
    push(1'b1, 19'd0, 24'hABCDEF);
    @(negedge clk);
    chk("abort_run_ready", 32'(pix_ready), 32'd1);
    chk("abort_run_busy", 32'(clear_busy), 32'd0);
    tick(); pix_valid = 1'b0;

    // A fresh clear after the abort restarts at address 0.
    clear_req = 1'b1; clear_color = 24'h0F0F0F;
    for (int a = 0; a < 5; a++) push(1'b1, 19'(a), 24'h0F0F0F);
    tick(); clear_req = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    tick(); reset_n = 1'b1;
    @(negedge clk);
    chk("end_busy", 32'(clear_busy), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
